ahb2apb_bridge_mp: RTL and testbench

Parametrised AHB-Lite to APB bridge. It is the next-generation replacement for the single-slave bridge and sits between the AHB interconnect and the peripheral APB segment. It decodes up to NUM_SLV APB slaves and honours PREADY wait states. It maps PSLVERR, decode misses and access timeouts onto a two-cycle AHB ERROR response.

---
 rtl/ahb2apb_bridge_mp_pkg.sv | 11 +
 rtl/ahb2apb_bridge_mp_if.sv | 32 +++
 rtl/ahb2apb_bridge_mp_decode.sv | 32 +++
 rtl/ahb2apb_bridge_mp.sv | 117 +++++++++++
 tb/tb_ahb2apb_bridge_mp.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb2apb_bridge_mp_pkg.sv
// ahb2apb_pkg: shared AHB/APB bridge types, response codes and FSM states
package ahb2apb_pkg;
    typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_t;
    typedef logic [1:0] hresp_t;
    localparam hresp_t OKAY  = 2'b00;
    localparam hresp_t ERROR = 2'b01;
    typedef enum logic [2:0] {S_IDLE, S_W_WAIT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_t;
    function automatic int idx_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ahb2apb_bridge_mp_if.sv
// ahb2apb_bridge_mp_if: AHB-Lite slave side and APB master side of the bridge
interface ahb2apb_bridge_mp_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4
);
    logic                        hselx;
    ahb2apb_pkg::htrans_t        htrans;
    logic                        hwrite;
    logic [ADDR_W-1:0]           haddr;
    logic [DATA_W-1:0]           hwdata;
    logic                        hready_in;
    logic [DATA_W-1:0]           hrdata;
    logic                        hreadyout;
    ahb2apb_pkg::hresp_t         hresp;
    logic [ADDR_W-1:0]           paddr;
    logic [NUM_SLV-1:0]          psel;
    logic                        penable;
    logic                        pwrite;
    logic [DATA_W-1:0]           pwdata;
    logic [NUM_SLV*DATA_W-1:0]   prdata;
    logic [NUM_SLV-1:0]          pready;
    logic [NUM_SLV-1:0]          pslverr;
    modport slave (
        input  hselx, htrans, hwrite, haddr, hwdata, hready_in, prdata, pready, pslverr,
        output hrdata, hreadyout, hresp, paddr, psel, penable, pwrite, pwdata
    );
    modport master (
        output hselx, htrans, hwrite, haddr, hwdata, hready_in, prdata, pready, pslverr,
        input  hrdata, hreadyout, hresp, paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/ahb2apb_bridge_mp_decode.sv
// ahb2apb_decode: slave index to one-hot select, miss flag and APB response slice
module ahb2apb_decode #(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 32,
    parameter int IW      = 2
) (
    input  logic [IW-1:0]             idx,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    output logic [NUM_SLV-1:0]        sel,
    output logic                      miss,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ready,
    output logic                      slverr
);
    always_comb begin
        sel    = '0;
        rdata  = '0;
        ready  = 1'b0;
        slverr = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == IW'(i)) begin
                sel[i] = 1'b1;
                rdata  = prdata[i*DATA_W +: DATA_W];
                ready  = pready[i];
                slverr = pslverr[i];
            end
        end
    end
    assign miss = ~|sel;
endmodule

// File: rtl/ahb2apb_bridge_mp.sv
// ahb2apb_bridge_mp: AHB-Lite to multi-slave APB bridge with wait states,
// PSLVERR/decode-miss/timeout mapped onto a two-cycle AHB ERROR response.
module ahb2apb_bridge_mp
    import ahb2apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input logic bclk,
    input logic bresetn,
    ahb2apb_bridge_mp_if.slave bus
);
    localparam int IW = idx_w(NUM_SLV);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    state_t state;
    logic [IW-1:0] idx_q, hidx, didx;
    logic [CW-1:0] cnt, cnt_n;
    logic [NUM_SLV-1:0] sel;
    logic [DATA_W-1:0] rdata;
    logic miss, ready, slverr, accept, timeout, unused_in;
    assign hidx      = NUM_SLV == 1 ? '0 : bus.haddr[SLV_LSB +: IW];
    assign accept    = bus.hselx & bus.htrans[1] & bus.hready_in & bus.hreadyout;
    // Decode the live address while able to accept, otherwise the latched index
    assign didx      = (state == S_IDLE || state == S_ERR2) ? hidx : idx_q;
    assign cnt_n     = &cnt ? cnt : cnt + 1'b1;
    assign timeout   = TIMEOUT != 0 && cnt_n == CW'(TIMEOUT);
    assign unused_in = ^{bus.htrans[0], bus.haddr};
    ahb2apb_decode #(.NUM_SLV(NUM_SLV), .DATA_W(DATA_W), .IW(IW)) u_decode (
        .idx(didx), .prdata(bus.prdata), .pready(bus.pready), .pslverr(bus.pslverr),
        .sel(sel), .miss(miss), .rdata(rdata), .ready(ready), .slverr(slverr)
    );
    always_ff @(posedge bclk or negedge bresetn) begin
        if (!bresetn) begin
            state         <= S_IDLE;
            bus.hreadyout <= 1'b1;
            bus.hresp     <= OKAY;
            bus.hrdata    <= '0;
            bus.psel      <= '0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
            idx_q         <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                S_IDLE, S_ERR2: begin
                    bus.hresp <= OKAY;
                    if (accept) begin
                        bus.paddr     <= bus.haddr;
                        bus.pwrite    <= bus.hwrite;
                        idx_q         <= hidx;
                        bus.hreadyout <= 1'b0;
                        // Writes always pass through W_WAIT so HWDATA is taken in its data phase
                        if (bus.hwrite) state <= S_W_WAIT;
                        else if (miss) begin
                            state     <= S_ERR1;
                            bus.hresp <= ERROR;
                        end else begin
                            state    <= S_SETUP;
                            bus.psel <= sel;
                            cnt      <= '0;
                        end
                    end else begin
                        state         <= S_IDLE;
                        bus.hreadyout <= 1'b1;
                    end
                end
                S_W_WAIT: begin
                    bus.pwdata <= bus.hwdata;
                    if (miss) begin
                        state     <= S_ERR1;
                        bus.hresp <= ERROR;
                    end else begin
                        state    <= S_SETUP;
                        bus.psel <= sel;
                        cnt      <= '0;
                    end
                end
                S_SETUP: begin
                    state       <= S_ACCESS;
                    bus.penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (ready) begin
                        bus.psel    <= '0;
                        bus.penable <= 1'b0;
                        if (slverr) begin
                            state     <= S_ERR1;
                            bus.hresp <= ERROR;
                        end else begin
                            state         <= S_IDLE;
                            bus.hreadyout <= 1'b1;
                            bus.hrdata    <= bus.pwrite ? bus.hrdata : rdata;
                        end
                    end else begin
                        cnt <= cnt_n;
                        if (timeout) begin
                            state       <= S_ERR1;
                            bus.hresp   <= ERROR;
                            bus.psel    <= '0;
                            bus.penable <= 1'b0;
                        end
                    end
                end
                S_ERR1: begin
                    state         <= S_ERR2;
                    bus.hreadyout <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// tb_ahb2apb_bridge_mp: directed bench with a transfer-level timing model for
// a 4-slave/TIMEOUT=4 bridge and a 3-slave bridge (decode-miss cases).
module tb_ahb2apb_bridge_mp;
    import ahb2apb_pkg::*;
    localparam int TO_A = 4;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    logic tgt;
    int nslv;
    logic hselx, hwrite, hready_in;
    htrans_t htrans;
    logic [31:0] haddr, hwdata;
    logic [3:0] rdy_mask, err_mask;
    int plan_waits, acc_k;
    bit plan_err, plan_hang;
    logic exp_rdy, exp_pen, exp_pwrite;
    hresp_t exp_resp;
    logic [3:0] exp_psel;
    logic [31:0] exp_paddr, exp_pwdata, exp_hrdata;
    bit chk_en;
    int n_chk, n_err;

    function automatic logic [31:0] sdata(int i);
        return i == 0 ? 32'h1111_1111 : i == 1 ? 32'hDEAD_BEEF : i == 2 ? 32'h3333_3333 : 32'h4444_4444;
    endfunction

    ahb2apb_bridge_mp_if #(.NUM_SLV(4)) ia ();
    ahb2apb_bridge_mp_if #(.NUM_SLV(3)) ib ();
    assign ia.hselx = hselx & ~tgt;
    assign ib.hselx = hselx & tgt;
    assign ia.htrans = htrans;    assign ib.htrans = htrans;
    assign ia.hwrite = hwrite;    assign ib.hwrite = hwrite;
    assign ia.haddr = haddr;      assign ib.haddr = haddr;
    assign ia.hwdata = hwdata;    assign ib.hwdata = hwdata;
    assign ia.hready_in = hready_in; assign ib.hready_in = hready_in;
    assign ia.prdata = {sdata(3), sdata(2), sdata(1), sdata(0)};
    assign ib.prdata = {sdata(2), sdata(1), sdata(0)};
    assign ia.pready = rdy_mask;  assign ib.pready = rdy_mask[2:0];
    assign ia.pslverr = err_mask; assign ib.pslverr = err_mask[2:0];

    ahb2apb_bridge_mp #(.NUM_SLV(4), .TIMEOUT(TO_A)) u_a (.bclk(clk), .bresetn(rst_n), .bus(ia.slave));
    ahb2apb_bridge_mp #(.NUM_SLV(3)) u_b (.bclk(clk), .bresetn(rst_n), .bus(ib.slave));

    logic cur_rdy, cur_pen, cur_pwrite;
    hresp_t cur_resp;
    logic [3:0] cur_psel;
    logic [31:0] cur_paddr, cur_pwdata, cur_hrdata;
    assign cur_rdy    = tgt ? ib.hreadyout : ia.hreadyout;
    assign cur_resp   = tgt ? ib.hresp : ia.hresp;
    assign cur_psel   = tgt ? {1'b0, ib.psel} : ia.psel;
    assign cur_pen    = tgt ? ib.penable : ia.penable;
    assign cur_pwrite = tgt ? ib.pwrite : ia.pwrite;
    assign cur_paddr  = tgt ? ib.paddr : ia.paddr;
    assign cur_pwdata = tgt ? ib.pwdata : ia.pwdata;
    assign cur_hrdata = tgt ? ib.hrdata : ia.hrdata;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endfunction

    // APB slave responder: the selected slave answers after plan_waits ACCESS
    // cycles; unselected slaves show ready/error so a wrong slice is exposed.
    always @(negedge clk) begin
        if (cur_pen && cur_psel != 4'b0) begin
            rdy_mask = (!plan_hang && acc_k == plan_waits) ? 4'hF : ~cur_psel;
            err_mask = plan_err ? 4'hF : ~cur_psel;
            acc_k++;
        end else begin
            acc_k = 0;
            rdy_mask = 4'h0;
            err_mask = 4'h0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hreadyout", 32'(cur_rdy), 32'(exp_rdy));
            chk("hresp", 32'(cur_resp), 32'(exp_resp));
            chk("psel", 32'(cur_psel), 32'(exp_psel));
            chk("penable", 32'(cur_pen), 32'(exp_pen));
            chk("pen_without_psel", 32'(cur_pen & ~|cur_psel), 32'd0);
            chk("paddr", cur_paddr, exp_paddr);
            chk("pwrite", 32'(cur_pwrite), 32'(exp_pwrite));
            chk("pwdata", cur_pwdata, exp_pwdata);
            chk("hrdata", cur_hrdata, exp_hrdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic rdy, input hresp_t resp, input logic [3:0] ps, input logic pen);
        exp_rdy = rdy; exp_resp = resp; exp_psel = ps; exp_pen = pen;
    endtask

    task automatic model_reset();
        set_exp(1'b1, OKAY, 4'h0, 1'b0);
        exp_paddr = '0; exp_pwrite = 1'b0; exp_pwdata = '0; exp_hrdata = '0;
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) begin
            step();
            hselx = busy; htrans = busy ? HT_BUSY : HT_IDLE; haddr = 32'h0000_1000; hwrite = busy;
            set_exp(1'b1, OKAY, 4'h0, 1'b0);
        end
        hselx = 1'b0; htrans = HT_IDLE;
    endtask

    task automatic noaccept();
        step();
        hselx = 1'b1; htrans = HT_NONSEQ; hready_in = 1'b0; hwrite = 1'b1; haddr = 32'h0000_1000;
        set_exp(1'b1, OKAY, 4'h0, 1'b0);
        step();
        hselx = 1'b0; htrans = HT_IDLE; hready_in = 1'b1;
        set_exp(1'b1, OKAY, 4'h0, 1'b0);
    endtask

    // Starts in the current cycle (address phase) and returns in the cycle
    // that completes the transfer (ready or ERR2), so callers can chain.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input bit err, input bit hang, input int stop_acc);
        int idx, nacc;
        logic [3:0] oh;
        idx = int'(addr[13:12]);
        oh = 4'b0001 << idx;
        hselx = 1'b1; htrans = HT_NONSEQ; hwrite = wr; haddr = addr;
        plan_waits = waits; plan_err = err; plan_hang = hang;
        step();
        hselx = 1'b0; htrans = HT_IDLE; hwrite = ~wr; haddr = 32'hFFFF_FFFF;
        exp_paddr = addr; exp_pwrite = wr;
        if (wr) begin
            set_exp(1'b0, OKAY, 4'h0, 1'b0);
            hwdata = wdata;
            step();
            hwdata = ~wdata;
            exp_pwdata = wdata;
        end
        if (idx >= nslv) begin
            set_exp(1'b0, ERROR, 4'h0, 1'b0);
            step();
            set_exp(1'b1, ERROR, 4'h0, 1'b0);
            return;
        end
        set_exp(1'b0, OKAY, oh, 1'b0);
        step();
        nacc = hang ? TO_A : waits + 1;
        for (int k = 0; k < nacc; k++) begin
            set_exp(1'b0, OKAY, oh, 1'b1);
            if (stop_acc == k + 1) return;
            step();
        end
        if (err || hang) begin
            set_exp(1'b0, ERROR, 4'h0, 1'b0);
            step();
            set_exp(1'b1, ERROR, 4'h0, 1'b0);
        end else begin
            if (!wr) exp_hrdata = sdata(idx);
            set_exp(1'b1, OKAY, 4'h0, 1'b0);
        end
    endtask

    initial begin
        n_chk = 0; n_err = 0; chk_en = 1'b0;
        tgt = 1'b0; nslv = 4;
        hselx = 1'b0; htrans = HT_IDLE; hwrite = 1'b0; haddr = '0; hwdata = '0; hready_in = 1'b1;
        plan_waits = 0; plan_err = 1'b0; plan_hang = 1'b0;
        rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_hreadyout", 32'(ia.hreadyout), 32'd1);
        chk("rst_psel", 32'(ia.psel), 32'd0);
        chk("rst_hrdata", ia.hrdata, 32'd0);
        idle(2, 1'b0);
        idle(2, 1'b1);
        noaccept();
        xfer(1'b0, 32'h0000_1004, '0, 0, 1'b0, 1'b0, 0);
        chk("read_hrdata_lit", ia.hrdata, 32'hDEAD_BEEF);
        chk("read_ready_lit", 32'(ia.hreadyout), 32'd1);
        idle(1, 1'b0);
        xfer(1'b1, 32'h0000_3008, 32'hA5A5_0001, 3, 1'b0, 1'b0, 0);
        chk("write_pwdata_lit", ia.pwdata, 32'hA5A5_0001);
        chk("write_hrdata_hold", ia.hrdata, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h0000_0000, '0, 0, 1'b1, 1'b0, 0);
        chk("slverr_err2_hresp", 32'(ia.hresp), 32'd1);
        chk("slverr_err2_ready", 32'(ia.hreadyout), 32'd1);
        idle(2, 1'b0);
        xfer(1'b0, 32'h0000_2010, '0, 1, 1'b0, 1'b0, 0);
        xfer(1'b1, 32'h0000_1000, 32'h1234_5678, 0, 1'b0, 1'b0, 0);
        idle(1, 1'b0);
        xfer(1'b0, 32'h0000_1000, '0, 0, 1'b0, 1'b1, 0);
        xfer(1'b0, 32'h0000_3004, '0, 0, 1'b0, 1'b0, 0);
        chk("after_timeout_hrdata", ia.hrdata, 32'h4444_4444);
        idle(1, 1'b0);
        xfer(1'b1, 32'h0000_2000, 32'h0BAD_0BAD, 2, 1'b1, 1'b0, 0);
        idle(2, 1'b0);
        xfer(1'b1, 32'h0000_2000, 32'hCAFE_0002, 0, 1'b0, 1'b1, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_psel", 32'(ia.psel), 32'd0);
        chk("async_rst_penable", 32'(ia.penable), 32'd0);
        chk("async_rst_hreadyout", 32'(ia.hreadyout), 32'd1);
        chk("async_rst_hresp", 32'(ia.hresp), 32'd0);
        model_reset();
        plan_hang = 1'b0;
        step();
        rst_n = 1'b1;
        idle(2, 1'b0);
        tgt = 1'b1; nslv = 3;
        idle(1, 1'b0);
        xfer(1'b0, 32'h0000_3000, '0, 0, 1'b0, 1'b0, 0);
        chk("miss_err2_hresp", 32'(ib.hresp), 32'd1);
        xfer(1'b0, 32'h0000_2004, '0, 0, 1'b0, 1'b0, 0);
        chk("b_read_hrdata_lit", ib.hrdata, 32'h3333_3333);
        xfer(1'b1, 32'h0000_3010, 32'h5555_AAAA, 0, 1'b0, 1'b0, 0);
        idle(2, 1'b0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1);
    end
endmodule
